transducer_array_fire: RTL

Multi-channel successor to the single-output transducer pulser. Arms all NUM_CH channels together on onYourMark, fires on goTrigger, and drives one charge pulse per channel after a shared fire delay plus a per-channel phase delay. Adds a channel mask, a charge-time safety clamp and an abort path. Sits between the trigger/timing controller and the transducer driver pins.

---
 rtl/transducer_fire_pkg.sv | 12 +
 rtl/transducer_channel_timer.sv | 69 ++++++
 rtl/transducer_array_fire.sv | 78 +++++++
 3 files changed

// File: rtl/transducer_fire_pkg.sv
// transducer_fire_pkg: shared state encoding, default widths and charge clamp for the array pulser
package transducer_fire_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, FIRING, DONE} fireStateT;
  localparam int DEF_NUM_CH = 8;
  localparam int DEF_CT_W = 9;
  localparam int DEF_PD_W = 16;
  localparam int DEF_FD_W = 32;
  localparam int DEF_MAX_CHARGE = 400;
  function automatic logic [15:0] clampCt(input logic [15:0] c, input logic [15:0] lim);
    return (c > lim) ? lim : c;
  endfunction
endpackage

// File: rtl/transducer_channel_timer.sv
// transducer_channel_timer: per-channel delay/charge counters; PULSE_BURST_EN adds repeated pulses
module transducer_channel_timer #(
  parameter int PD_W = 33,
  parameter int CT_W = 9
) (
  input  logic            clk,
  input  logic            load,
  input  logic            run,
  input  logic            clear,
  input  logic            mask,
  input  logic [PD_W-1:0] pdIn,
  input  logic [CT_W-1:0] ctIn,
`ifdef PULSE_BURST_EN
  input  logic [7:0]      burstIn,
  input  logic [15:0]     gapIn,
`endif
  output logic            pulse,
  output logic            done
);
  logic [PD_W-1:0] pd;
  logic [CT_W-1:0] ct;
`ifdef PULSE_BURST_EN
  logic [CT_W-1:0] ctLoad;
  logic [7:0] left;
  logic [15:0] gap;
`endif
  always_ff @(posedge clk) begin
    if (clear) begin
      pd <= '0;
      ct <= '0;
      pulse <= 1'b0;
      done <= 1'b0;
`ifdef PULSE_BURST_EN
      ctLoad <= '0;
      left <= '0;
      gap <= '0;
`endif
    end else if (load) begin
      pd <= pdIn;
      ct <= ctIn;
      pulse <= 1'b0;
      done <= !mask;
`ifdef PULSE_BURST_EN
      ctLoad <= ctIn;
      left <= (burstIn == 8'd0) ? 8'd1 : burstIn;
      gap <= gapIn;
`endif
    end else if (run && !done) begin
      if (pd != '0) pd <= pd - PD_W'(1);
      else if (ct != '0) begin
        pulse <= 1'b1;
        ct <= ct - CT_W'(1);
      end
`ifdef PULSE_BURST_EN
      // the cycle that ends a pulse is already the first gap cycle
      else if (left > 8'd1 && ctLoad != '0) begin
        left <= left - 8'd1;
        pulse <= (gap == 16'd0);
        ct <= (gap == 16'd0) ? ctLoad - CT_W'(1) : ctLoad;
        pd <= (gap == 16'd0) ? '0 : PD_W'(gap) - PD_W'(1);
      end
`endif
      else begin
        pulse <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/transducer_array_fire.sv
// transducer_array_fire: arms, fires and aborts NUM_CH phased charge pulses; PULSE_BURST_EN enables bursts
module transducer_array_fire
  import transducer_fire_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CT_W = DEF_CT_W,
  parameter int PD_W = DEF_PD_W,
  parameter int FD_W = DEF_FD_W,
  parameter int MAX_CHARGE = DEF_MAX_CHARGE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   isActive,
  input  logic                   onYourMark,
  input  logic                   goTrigger,
  input  logic [NUM_CH-1:0]      channelMask,
  input  logic [NUM_CH*CT_W-1:0] chargeTime,
  input  logic [NUM_CH*PD_W-1:0] phaseDelay,
  input  logic [FD_W-1:0]        fireDelay,
`ifdef PULSE_BURST_EN
  input  logic [7:0]             burstCount,
  input  logic [15:0]            burstGap,
`endif
  output logic [NUM_CH-1:0]      transducerOutput,
  output logic                   fireComplete,
  output logic                   busy,
  output logic                   aborted
);
  localparam int PW = FD_W + 1;
  fireStateT state, nextState;
  logic [NUM_CH-1:0] doneV;
  logic abort, load, run, clear, allDone;
  assign allDone = &doneV;
  assign load = isActive && state == IDLE && onYourMark;
  assign run = state == FIRING && onYourMark;
  assign clear = rst || !isActive || abort;
  assign busy = state == ARMED || state == FIRING;
  always_ff @(posedge clk) begin
    state <= (rst || !isActive) ? IDLE : nextState;
    fireComplete <= !rst && (!isActive || nextState == DONE);
    aborted <= !rst && isActive && abort;
  end
  always_comb begin
    nextState = state;
    abort = 1'b0;
    case (state)
      IDLE: if (onYourMark) nextState = goTrigger ? FIRING : ARMED;
      ARMED: nextState = !onYourMark ? IDLE : goTrigger ? FIRING : ARMED;
      FIRING: begin
        abort = !onYourMark;
        nextState = !onYourMark ? IDLE : allDone ? DONE : FIRING;
      end
      DONE: if (!onYourMark) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PW-1:0] pdIn;
    logic [CT_W-1:0] ctIn;
    assign pdIn = PW'(phaseDelay[i*PD_W +: PD_W]) + PW'(fireDelay);
    assign ctIn = CT_W'(clampCt(16'(chargeTime[i*CT_W +: CT_W]), 16'(MAX_CHARGE)));
    transducer_channel_timer #(.PD_W(PW), .CT_W(CT_W)) u_timer (
      .clk(clk),
      .load(load),
      .run(run),
      .clear(clear),
      .mask(channelMask[i]),
      .pdIn(pdIn),
      .ctIn(ctIn),
`ifdef PULSE_BURST_EN
      .burstIn(burstCount),
      .gapIn(burstGap),
`endif
      .pulse(transducerOutput[i]),
      .done(doneV[i])
    );
  end
endmodule
